// File: rtl/sc_game_pkg.sv
// Shared types and widths for the game-flow controller and its progress counter.
package sc_game_pkg;

  localparam int PROGRESS_W = 5;
  localparam int LEVEL_W    = 3;
  localparam int LIVES_W    = 3;
  localparam int PAUSE_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_CRASH    = 3'd2,
    ST_LVLDONE  = 3'd3,
    ST_WIN      = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_t;

endpackage

// File: rtl/sc_level_sequencer_if.sv
// Signals between the game input logic / progress counter and the level sequencer.
interface sc_level_sequencer_if import sc_game_pkg::*;;

  logic                  SC_LEVELSEQUENCER_Start_in;
  logic                  SC_LEVELSEQUENCER_Crash_in;
  logic [PROGRESS_W-1:0] SC_LEVELSEQUENCER_Progress_InBus;
  logic                  SC_LEVELSEQUENCER_RunEnable_out;
  logic                  SC_LEVELSEQUENCER_Count_out;
  logic                  SC_LEVELSEQUENCER_LevelClear_out;
  logic [LEVEL_W-1:0]    SC_LEVELSEQUENCER_Level_OutBus;
  logic [LIVES_W-1:0]    SC_LEVELSEQUENCER_Lives_OutBus;
  logic                  SC_LEVELSEQUENCER_Win_out;
  logic                  SC_LEVELSEQUENCER_GameOver_out;

  // Game side: supplies start/crash and the counter value, observes control lines.
  modport master (
    output SC_LEVELSEQUENCER_Start_in, SC_LEVELSEQUENCER_Crash_in, SC_LEVELSEQUENCER_Progress_InBus,
    input  SC_LEVELSEQUENCER_RunEnable_out, SC_LEVELSEQUENCER_Count_out,
           SC_LEVELSEQUENCER_LevelClear_out, SC_LEVELSEQUENCER_Level_OutBus,
           SC_LEVELSEQUENCER_Lives_OutBus, SC_LEVELSEQUENCER_Win_out, SC_LEVELSEQUENCER_GameOver_out
  );

  modport slave (
    input  SC_LEVELSEQUENCER_Start_in, SC_LEVELSEQUENCER_Crash_in, SC_LEVELSEQUENCER_Progress_InBus,
    output SC_LEVELSEQUENCER_RunEnable_out, SC_LEVELSEQUENCER_Count_out,
           SC_LEVELSEQUENCER_LevelClear_out, SC_LEVELSEQUENCER_Level_OutBus,
           SC_LEVELSEQUENCER_Lives_OutBus, SC_LEVELSEQUENCER_Win_out, SC_LEVELSEQUENCER_GameOver_out
  );

endinterface

// File: rtl/sc_step_prescaler.sv
// Step-rate prescaler: counts 0..(STEP_DIV>>shift)-1 and pulses tc for one cycle at the top.
module sc_step_prescaler #(
  parameter int STEP_DIV = 25_000_000,
  parameter int SHIFT_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [SHIFT_W-1:0] shift,
  output logic               tc
);

  localparam int          CNT_W = $clog2(STEP_DIV);
  localparam logic [31:0] DIV32 = 32'(STEP_DIV);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      div_shifted;
  logic [CNT_W-1:0] term;

  assign div_shifted = DIV32 >> shift;
  assign term        = CNT_W'(div_shifted - 32'd1);
  assign tc          = en && (cnt == term);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sc_level_sequencer.sv
// Game-flow controller: drives the progress counter's run/count/clear lines and tracks levels and lives.
module sc_level_sequencer import sc_game_pkg::*; #(
  parameter int STEP_DIV     = 25_000_000,
  parameter int LEVEL_LENGTH = 31,
  parameter int NUM_LEVELS   = 4,
  parameter int LIVES        = 3,
  parameter int CRASH_PAUSE  = 8
) (
  input logic                 SC_LEVELSEQUENCER_CLOCK_50,
  input logic                 SC_LEVELSEQUENCER_RESET_InLow,
  sc_level_sequencer_if.slave bus
);

  if (((STEP_DIV >> (NUM_LEVELS - 1)) < 2) || (LEVEL_LENGTH < 1) || (LEVEL_LENGTH > 31) ||
      (NUM_LEVELS < 1) || (NUM_LEVELS > 8) || (LIVES < 1) || (LIVES > 7) ||
      (CRASH_PAUSE < 1) || (CRASH_PAUSE > 15)) begin : g_param_check
    $error("sc_level_sequencer: illegal parameter combination");
  end

  localparam logic [PROGRESS_W-1:0] LEVEL_END  = PROGRESS_W'(LEVEL_LENGTH);
  localparam logic [LEVEL_W-1:0]    LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LIVES_W-1:0]    FULL_LIVES = LIVES_W'(LIVES);
  localparam logic [PAUSE_W-1:0]    LAST_PAUSE = PAUSE_W'(CRASH_PAUSE - 1);

  state_t               state, state_nx;
  logic [LEVEL_W-1:0]   level, level_nx;
  logic [LIVES_W-1:0]   lives, lives_nx;
  logic [PAUSE_W-1:0]   pause, pause_nx;
  logic                 count_n, count_n_nx;
  logic                 level_clear_n, level_clear_n_nx;
  logic                 run_enable, win, game_over;
  logic                 presc_en, presc_clr, tc;

  logic                  start, crash;
  logic [PROGRESS_W-1:0] progress;

  assign start    = bus.SC_LEVELSEQUENCER_Start_in;
  assign crash    = bus.SC_LEVELSEQUENCER_Crash_in;
  assign progress = bus.SC_LEVELSEQUENCER_Progress_InBus;

  sc_step_prescaler #(
    .STEP_DIV (STEP_DIV),
    .SHIFT_W  (LEVEL_W)
  ) u_prescaler (
    .clk   (SC_LEVELSEQUENCER_CLOCK_50),
    .rst_n (SC_LEVELSEQUENCER_RESET_InLow),
    .en    (presc_en),
    .clr   (presc_clr),
    .shift (level),
    .tc    (tc)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nx         = state;
    level_nx         = level;
    lives_nx         = lives;
    pause_nx         = pause;
    count_n_nx       = 1'b1;
    level_clear_n_nx = 1'b1;
    presc_en         = 1'b0;
    presc_clr        = 1'b0;

    unique case (state)
      ST_IDLE, ST_WIN, ST_GAMEOVER: begin
        if (start) begin
          state_nx  = ST_RUN;
          level_nx  = '0;
          lives_nx  = FULL_LIVES;
          presc_clr = 1'b1;
        end
      end
      ST_RUN: begin
        presc_en = 1'b1;
        // Level completion outranks a simultaneous crash and swallows the step.
        if (progress == LEVEL_END) begin
          state_nx         = ST_LVLDONE;
          level_clear_n_nx = 1'b0;
        end else if (crash) begin
          lives_nx = lives - 1'b1;
          if (lives == LIVES_W'(1)) begin
            state_nx = ST_GAMEOVER;
          end else begin
            state_nx  = ST_CRASH;
            pause_nx  = '0;
            presc_clr = 1'b1;
          end
        end else if (tc) begin
          count_n_nx = 1'b0;
        end
      end
      ST_CRASH: begin
        presc_en = 1'b1;
        if (tc) begin
          if (pause == LAST_PAUSE) begin
            state_nx  = ST_RUN;
            pause_nx  = '0;
            presc_clr = 1'b1;
          end else begin
            pause_nx = pause + 1'b1;
          end
        end
      end
      ST_LVLDONE: begin
        presc_clr = 1'b1;
        if (level == LAST_LEVEL) begin
          state_nx = ST_WIN;
        end else begin
          state_nx = ST_RUN;
          level_nx = level + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge SC_LEVELSEQUENCER_CLOCK_50 or negedge SC_LEVELSEQUENCER_RESET_InLow) begin
    if (!SC_LEVELSEQUENCER_RESET_InLow) begin
      state         <= ST_IDLE;
      level         <= '0;
      lives         <= FULL_LIVES;
      pause         <= '0;
      count_n       <= 1'b1;
      level_clear_n <= 1'b1;
      run_enable    <= 1'b0;
      win           <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state         <= state_nx;
      level         <= level_nx;
      lives         <= lives_nx;
      pause         <= pause_nx;
      count_n       <= count_n_nx;
      level_clear_n <= level_clear_n_nx;
      run_enable    <= state_nx inside {ST_RUN, ST_CRASH, ST_LVLDONE};
      win           <= (state_nx == ST_WIN);
      game_over     <= (state_nx == ST_GAMEOVER);
    end
  end

  assign bus.SC_LEVELSEQUENCER_RunEnable_out  = run_enable;
  assign bus.SC_LEVELSEQUENCER_Count_out      = count_n;
  assign bus.SC_LEVELSEQUENCER_LevelClear_out = level_clear_n;
  assign bus.SC_LEVELSEQUENCER_Level_OutBus   = level;
  assign bus.SC_LEVELSEQUENCER_Lives_OutBus   = lives;
  assign bus.SC_LEVELSEQUENCER_Win_out        = win;
  assign bus.SC_LEVELSEQUENCER_GameOver_out   = game_over;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Directed bench for sc_level_sequencer with a behavioural model of the 5-bit progress counter.
module tb_sc_level_sequencer;
  import sc_game_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_level_sequencer_if bus ();

  sc_level_sequencer #(
    .STEP_DIV     (8),
    .LEVEL_LENGTH (4),
    .NUM_LEVELS   (2),
    .LIVES        (2),
    .CRASH_PAUSE  (2)
  ) dut (
    .SC_LEVELSEQUENCER_CLOCK_50    (clk),
    .SC_LEVELSEQUENCER_RESET_InLow (rst_n),
    .bus                           (bus.slave)
  );

  wire               run_en    = bus.SC_LEVELSEQUENCER_RunEnable_out;
  wire               count_n   = bus.SC_LEVELSEQUENCER_Count_out;
  wire               lclr_n    = bus.SC_LEVELSEQUENCER_LevelClear_out;
  wire [LEVEL_W-1:0] level     = bus.SC_LEVELSEQUENCER_Level_OutBus;
  wire [LIVES_W-1:0] lives     = bus.SC_LEVELSEQUENCER_Lives_OutBus;
  wire               win       = bus.SC_LEVELSEQUENCER_Win_out;
  wire               game_over = bus.SC_LEVELSEQUENCER_GameOver_out;

  // Progress counter: cleared while run is low or level-clear is low, else increments on Count low.
  logic [PROGRESS_W-1:0] progress = '0;
  always @(posedge clk) begin
    if (!run_en || !lclr_n) progress <= '0;
    else if (!count_n)      progress <= progress + 5'd1;
  end
  assign bus.SC_LEVELSEQUENCER_Progress_InBus = progress;

  int checks = 0;
  int errors = 0;
  int n;
  int pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic set_start(input logic v);
    bus.SC_LEVELSEQUENCER_Start_in = v;
  endtask

  task automatic set_crash(input logic v);
    bus.SC_LEVELSEQUENCER_Crash_in = v;
  endtask

  task automatic pulse_start();
    set_start(1'b1);
    tick(1);
    set_start(1'b0);
  endtask

  task automatic pulse_crash();
    set_crash(1'b1);
    tick(1);
    set_crash(1'b0);
  endtask

  // Cycles from now until Count is low (0 if already low); bounded.
  task automatic wait_count(output int cycles);
    cycles = 0;
    while (count_n !== 1'b0 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Cycles from the current Count pulse to the next one.
  task automatic next_count(output int cycles);
    @(negedge clk);
    wait_count(cycles);
    cycles++;
  endtask

  task automatic wait_clear(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (lclr_n !== 1'b0 && cycles < 200);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_run_en"},    32'(run_en),    32'd0);
    check({tag, "_count_n"},   32'(count_n),   32'd1);
    check({tag, "_lclr_n"},    32'(lclr_n),    32'd1);
    check({tag, "_level"},     32'(level),     32'd0);
    check({tag, "_lives"},     32'(lives),     32'd2);
    check({tag, "_win"},       32'(win),       32'd0);
    check({tag, "_game_over"}, 32'(game_over), 32'd0);
  endtask

  initial begin
    set_start(1'b0);
    set_crash(1'b0);
    rst_n = 1'b0;
    tick(2);
    check_reset_values("reset");

    // Idle for 20 cycles: no control activity expected.
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (count_n !== 1'b1 || lclr_n !== 1'b1 || run_en !== 1'b0) pulses++;
    end
    check("idle_activity", 32'(pulses), 32'd0);
    check("idle_lives", 32'(lives), 32'd2);

    // Level 0: steps every 8 cycles.
    pulse_start();
    check("start_run_en", 32'(run_en), 32'd1);
    check("start_level", 32'(level), 32'd0);
    wait_count(n);
    check("l0_first_step", 32'(n), 32'd8);
    for (int k = 0; k < 3; k++) begin
      next_count(n);
      check("l0_step_gap", 32'(n), 32'd8);
    end
    wait_clear(n);
    check("l0_clear_delay", 32'(n), 32'd2);
    check("l0_clear_no_count", 32'(count_n), 32'd1);
    tick(1);
    check("l0_clear_width", 32'(lclr_n), 32'd1);
    check("l1_level", 32'(level), 32'd1);
    check("l1_progress_cleared", 32'(progress), 32'd0);

    // Level 1: steps every 4 cycles, completion leads to WIN.
    wait_count(n);
    check("l1_first_step", 32'(n), 32'd4);
    for (int k = 0; k < 3; k++) begin
      next_count(n);
      check("l1_step_gap", 32'(n), 32'd4);
    end
    wait_clear(n);
    check("l1_clear_delay", 32'(n), 32'd2);
    tick(1);
    check("win_flag", 32'(win), 32'd1);
    check("win_run_en", 32'(run_en), 32'd0);
    check("win_level", 32'(level), 32'd1);
    check("win_progress", 32'(progress), 32'd0);

    // Restart from WIN, then crash at progress 2.
    pulse_start();
    check("restart_win", 32'(win), 32'd0);
    check("restart_level", 32'(level), 32'd0);
    check("restart_lives", 32'(lives), 32'd2);
    wait_count(n);
    check("r_first_step", 32'(n), 32'd8);
    next_count(n);
    check("r_step_gap", 32'(n), 32'd8);
    tick(1);
    check("pre_crash_progress", 32'(progress), 32'd2);
    pulse_crash();
    check("crash_lives", 32'(lives), 32'd1);
    check("crash_run_en", 32'(run_en), 32'd1);
    check("crash_game_over", 32'(game_over), 32'd0);
    tick(5);
    pulse_crash();
    check("crash_ignored_lives", 32'(lives), 32'd1);
    wait_count(n);
    check("crash_pause_len", 32'(n), 32'd18);
    check("crash_progress_kept", 32'(progress), 32'd2);

    // Second crash ends the game.
    tick(1);
    check("resume_progress", 32'(progress), 32'd3);
    pulse_crash();
    check("go_flag", 32'(game_over), 32'd1);
    check("go_run_en", 32'(run_en), 32'd0);
    check("go_lives", 32'(lives), 32'd0);
    tick(1);
    check("go_progress", 32'(progress), 32'd0);
    pulse_crash();
    check("go_crash_flag", 32'(game_over), 32'd1);
    check("go_crash_lives", 32'(lives), 32'd0);
    pulse_start();
    check("go_restart_flag", 32'(game_over), 32'd0);
    check("go_restart_run_en", 32'(run_en), 32'd1);
    check("go_restart_lives", 32'(lives), 32'd2);

    // Crash in the same cycle as level completion.
    wait_count(n);
    check("g_first_step", 32'(n), 32'd8);
    for (int k = 0; k < 3; k++) begin
      next_count(n);
      check("g_step_gap", 32'(n), 32'd8);
    end
    tick(1);
    check("tie_progress", 32'(progress), 32'd4);
    pulse_crash();
    check("tie_lclr", 32'(lclr_n), 32'd0);
    check("tie_lives", 32'(lives), 32'd2);
    check("tie_game_over", 32'(game_over), 32'd0);
    tick(1);
    check("tie_level", 32'(level), 32'd1);
    check("tie_run_en", 32'(run_en), 32'd1);

    // Asynchronous reset in the middle of RUN, with a start pulse while held.
    tick(3);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    set_start(1'b1);
    tick(2);
    set_start(1'b0);
    check("reset_beats_start", 32'(run_en), 32'd0);
    check("reset_progress", 32'(progress), 32'd0);
    rst_n = 1'b1;
    tick(2);
    check("post_reset_idle", 32'(run_en), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
